sha3_found_nonce_queue: RTL and testbench

- Sits directly downstream of the SHA3 packed-pipeline scanner.
- Captures every found event (nonce plus one selected 64-bit hash word) into a small FIFO so the host/AXI side can drain results at its own pace.
- The scanner keeps running across multiple hits without losing them.
- Also tracks scan completion and counts results dropped on overflow.

---
 rtl/sha3_found_nonce_queue.sv | 137 +++++++++++++
 tb/tb_sha3_found_nonce_queue.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/sha3_found_nonce_queue.sv
`default_nettype none
// ============================================================================
// Module      : sha3_found_nonce_queue
// Description : Captures each scanner found event (nonce and one hash word)
//               into a FIFO for the host, with a scan-done flag and a
//               saturating count of events dropped on overflow.
// Revision    : 1.0 - initial release
// ============================================================================
module sha3_found_nonce_queue #(
    parameter int DEPTH           = 8,
    parameter int HASH_WORD_INDEX = 3
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       found,
    input  logic [31:0]                nonce,
    input  logic [63:0]                hash_word,
    input  logic                       busy,
    input  logic                       flush,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_nonce,
    output logic [63:0]                out_hash,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty,
    output logic [15:0]                overflow_count,
    output logic                       scan_done
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) ||
        (HASH_WORD_INDEX < 0) || (HASH_WORD_INDEX > 24)) begin : g_param_check
        $error("sha3_found_nonce_queue: DEPTH must be a power of two >= 2 and HASH_WORD_INDEX in 0..24");
    end

    logic [95:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [15:0]   ovf_q, ovf_d;
    logic          found_q, found_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic          w_push_req;
    logic          w_pop;
    logic          w_push_ok;
    logic          w_full;
    logic          w_empty;
    logic [95:0]   w_head;

    assign w_full  = (count_q == CW'(DEPTH));
    assign w_empty = (count_q == '0);
    assign w_head  = mem_q[rd_ptr_q];

    always_comb begin
        w_push_req = found & ~found_q;
        w_pop      = ~w_empty & out_ready;
        // A pop in the same cycle frees the slot, so a full queue still accepts.
        w_push_ok  = w_push_req & ~flush & (~w_full | w_pop);

        found_d  = found;
        busy_d   = busy;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        done_d   = done_q;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = '0;
            done_d   = 1'b0;
        end else begin
            if (w_push_ok) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (w_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({w_push_ok, w_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
            if (w_push_req && w_full && !w_pop && (ovf_q != 16'hFFFF)) begin
                ovf_d = ovf_q + 16'd1;
            end
            if (busy_q && !busy) begin
                done_d = 1'b1;
            end
        end
    end

    // found_q resets high so a found level held through reset is not an event.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            found_q  <= 1'b1;
            busy_q   <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            found_q  <= found_d;
            busy_q   <= busy_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            done_q   <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            mem_q[wr_ptr_q] <= {nonce, hash_word};
        end
    end

    assign out_valid      = ~w_empty;
    assign out_nonce      = w_empty ? 32'd0 : w_head[95:64];
    assign out_hash       = w_empty ? 64'd0 : w_head[63:0];
    assign count          = count_q;
    assign full           = w_full;
    assign empty          = w_empty;
    assign overflow_count = ovf_q;
    assign scan_done      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_sha3_found_nonce_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_sha3_found_nonce_queue
// Description : Scoreboard bench for sha3_found_nonce_queue (DEPTH = 8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sha3_found_nonce_queue;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rstn;
    logic        found;
    logic [31:0] nonce;
    logic [63:0] hash_word;
    logic        busy;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_nonce;
    logic [63:0] out_hash;
    logic [3:0]  count;
    logic        full;
    logic        empty;
    logic [15:0] overflow_count;
    logic        scan_done;

    sha3_found_nonce_queue #(.DEPTH(DEPTH), .HASH_WORD_INDEX(3)) u_dut (
        .clk            (clk),
        .rstn           (rstn),
        .found          (found),
        .nonce          (nonce),
        .hash_word      (hash_word),
        .busy           (busy),
        .flush          (flush),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_nonce      (out_nonce),
        .out_hash       (out_hash),
        .count          (count),
        .full           (full),
        .empty          (empty),
        .overflow_count (overflow_count),
        .scan_done      (scan_done)
    );

    always #5 clk = ~clk;

    int          vectors = 0;
    int          miscompares = 0;
    logic [95:0] exp_q [$];
    logic [15:0] exp_ovf = 16'd0;

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] hash_of(input logic [31:0] n);
        return {~n, n ^ 32'h5A5A_0000};
    endfunction

    // Expected FIFO effect of a found rising edge seen at the next clock edge.
    task automatic model_push(input logic [31:0] n, input logic [63:0] h, input logic popping);
        if (exp_q.size() < DEPTH || popping) begin
            exp_q.push_back({n, h});
        end else if (exp_ovf != 16'hFFFF) begin
            exp_ovf++;
        end
    endtask

    task automatic pulse(input logic [31:0] n);
        found     = 1'b1;
        nonce     = n;
        hash_word = hash_of(n);
        model_push(n, hash_of(n), 1'b0);
        step();
        found = 1'b0;
        step();
    endtask

    task automatic pop_one();
        logic [95:0] e;
        if (exp_q.size() == 0) begin
            check("pop_underflow_model", {95'd0, out_valid}, 96'd0);
        end else begin
            e = exp_q.pop_front();
            check("pop_valid", {95'd0, out_valid}, 96'd1);
            check("pop_entry", {out_nonce, out_hash}, e);
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
        end
    endtask

    task automatic drain_all();
        while (exp_q.size() != 0) pop_one();
        check("drain_empty", {95'd0, empty}, 96'd1);
        check("drain_count", {92'd0, count}, 96'd0);
    endtask

    task automatic check_state(input string tag);
        check({tag, "_count"}, {92'd0, count}, 96'(exp_q.size()));
        check({tag, "_ovf"}, {80'd0, overflow_count}, {80'd0, exp_ovf});
        check({tag, "_full"}, {95'd0, full}, 96'(exp_q.size() == DEPTH));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0; found = 1'b0; nonce = '0; hash_word = '0;
        busy = 1'b0; flush = 1'b0; out_ready = 1'b0;
        repeat (3) step();
        rstn = 1'b1;
        step();

        check("rst_count", {92'd0, count}, 96'd0);
        check("rst_empty_full_valid", {93'd0, empty, full, out_valid}, 96'b100);
        check("rst_ovf_done", {79'd0, overflow_count, scan_done}, 96'd0);
        check("rst_out", {out_nonce, out_hash}, 96'd0);

        // Single capture held at the head until accepted.
        found = 1'b1; nonce = 32'h0000_1234; hash_word = 64'hDEAD_BEEF_0000_0001;
        model_push(nonce, hash_word, 1'b0);
        step();
        found = 1'b0;
        check("t1_valid", {95'd0, out_valid}, 96'd1);
        check("t1_head", {out_nonce, out_hash}, {32'h1234, 64'hDEAD_BEEF_0000_0001});
        check_state("t1");
        repeat (3) step();
        check("t1_hold", {out_nonce, out_hash}, {32'h1234, 64'hDEAD_BEEF_0000_0001});
        pop_one();
        check("t1_empty", {95'd0, empty}, 96'd1);

        // A held level is one event.
        found = 1'b1; nonce = 32'h55; hash_word = hash_of(32'h55);
        model_push(nonce, hash_word, 1'b0);
        repeat (10) step();
        found = 1'b0;
        step();
        check_state("hold");
        drain_all();

        for (int i = 1; i <= 3; i++) pulse(32'(i));
        check_state("three");
        drain_all();

        // Overflow: 11 events into 8 slots.
        for (int i = 1; i <= 11; i++) pulse(32'(i));
        check_state("ovf");
        check("ovf_value", {80'd0, overflow_count}, 96'd3);
        drain_all();

        // Simultaneous push and pop while full.
        for (int i = 0; i < DEPTH; i++) pulse(32'h100 + 32'(i));
        check_state("fill");
        check("sim_head", {out_nonce, out_hash}, exp_q[0]);
        void'(exp_q.pop_front());
        found = 1'b1; nonce = 32'hABC; hash_word = hash_of(32'hABC); out_ready = 1'b1;
        model_push(nonce, hash_word, 1'b1);
        step();
        found = 1'b0; out_ready = 1'b0;
        step();
        check_state("sim");
        check("sim_tail", exp_q[DEPTH-1], {32'hABC, hash_of(32'hABC)});
        drain_all();

        // scan_done sticky on busy falling edge.
        busy = 1'b1; step();
        busy = 1'b0; step();
        check("done_set", {95'd0, scan_done}, 96'd1);
        repeat (3) step();
        check("done_sticky", {95'd0, scan_done}, 96'd1);

        // Flush: start from a clean slate, then build 4 entries with ovf=2.
        flush = 1'b1; step(); flush = 1'b0;
        exp_q.delete(); exp_ovf = 16'd0;
        check_state("flush0");
        for (int i = 0; i < DEPTH + 2; i++) pulse(32'h200 + 32'(i));
        for (int i = 0; i < 4; i++) pop_one();
        check_state("pre_flush");
        busy = 1'b1; step(); busy = 1'b0; step();
        check("pre_flush_done", {95'd0, scan_done}, 96'd1);
        found = 1'b1; nonce = 32'h999; hash_word = hash_of(32'h999);
        flush = 1'b1; out_ready = 1'b1;
        step();
        flush = 1'b0; out_ready = 1'b0;
        exp_q.delete(); exp_ovf = 16'd0;
        check_state("flush");
        check("flush_done", {94'd0, scan_done, out_valid}, 96'd0);
        found = 1'b0; step();
        check("flush_no_capture", {92'd0, count}, 96'd0);

        // busy fall coinciding with flush: flush wins.
        busy = 1'b1; step();
        busy = 1'b0; flush = 1'b1; step();
        flush = 1'b0;
        check("flush_vs_done", {95'd0, scan_done}, 96'd0);

        // Asynchronous reset mid-drain with found held.
        for (int i = 1; i <= 3; i++) pulse(32'h300 + 32'(i));
        pop_one();
        found = 1'b1; nonce = 32'h777; hash_word = hash_of(32'h777);
        #2 rstn = 1'b0;
        #1;
        exp_q.delete(); exp_ovf = 16'd0;
        check("arst_count", {92'd0, count}, 96'd0);
        check("arst_flags", {93'd0, empty, full, out_valid}, 96'b100);
        check("arst_out", {out_nonce, out_hash}, 96'd0);
        step(); step();
        rstn = 1'b1;
        repeat (3) step();
        check("arst_no_capture", {92'd0, count}, 96'd0);
        found = 1'b0; step();
        found = 1'b1;
        model_push(nonce, hash_word, 1'b0);
        step();
        found = 1'b0;
        check_state("arst_recap");
        drain_all();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
